// File: rtl/serial_cmd_receiver.sv
// 8N1 UART receiver that turns ASCII command characters into a 3-bit number
// plus a control strobe, with number held stable around the strobe.
module serial_cmd_receiver #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [2:0] number,
    output logic       control,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    // state    | meaning
    // R_IDLE   | line idle, waiting for a start edge
    // R_START  | half-bit wait, confirm start bit
    // R_DATA   | sampling 8 data bits, LSB first
    // R_STOP   | sampling stop bit
    // S_IDLE   | no strobe in flight, number holds last value
    // S_SETUP  | number loaded, waiting before control rises
    // S_PULSE  | control high
    // S_HOLD   | control low, number still held

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SMAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam logic [CW-1:0] BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);
    localparam logic [SW-1:0] PULSE_LOAD = SW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} st_state_t;

    logic          rx_meta, rx_sync;
    rx_state_t     r_state, r_nxt;
    logic [CW-1:0] clk_cnt, cnt_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic          byte_ok, ferr_set;
    logic          cmd_valid;
    logic [2:0]    cmd_num;

    st_state_t     s_state, s_nxt;
    logic [SW-1:0] s_cnt, sc_nxt;
    logic [2:0]    num_nxt, pend_num, pend_nxt;
    logic          ctl_nxt, pend_full, pend_full_nxt, ovr_set, slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            r_state   <= R_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            s_state   <= S_IDLE;
            s_cnt     <= '0;
            number    <= '0;
            control   <= 1'b0;
            pend_full <= 1'b0;
            pend_num  <= '0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            r_state   <= r_nxt;
            clk_cnt   <= cnt_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= sh_nxt;
            frame_err <= ferr_set;
            s_state   <= s_nxt;
            s_cnt     <= sc_nxt;
            number    <= num_nxt;
            control   <= ctl_nxt;
            pend_full <= pend_full_nxt;
            pend_num  <= pend_nxt;
            overrun   <= ovr_set;
        end
    end

    always_comb begin
        r_nxt    = r_state;
        cnt_nxt  = clk_cnt;
        bit_nxt  = bit_cnt;
        sh_nxt   = shreg;
        byte_ok  = 1'b0;
        ferr_set = 1'b0;
        case (r_state)
            R_IDLE: if (!rx_sync) begin
                r_nxt   = R_START;
                cnt_nxt = HALF_LOAD;
                bit_nxt = '0;
            end
            R_START: if (clk_cnt == '0) begin
                // a start bit that is gone by mid-bit is a glitch, not an error
                if (!rx_sync) begin
                    r_nxt   = R_DATA;
                    cnt_nxt = BIT_LOAD;
                end else begin
                    r_nxt = R_IDLE;
                end
            end else begin
                cnt_nxt = clk_cnt - CW'(1);
            end
            R_DATA: if (clk_cnt == '0) begin
                sh_nxt  = {rx_sync, shreg[7:1]};
                cnt_nxt = BIT_LOAD;
                if (bit_cnt == 3'd7) r_nxt = R_STOP;
                else bit_nxt = bit_cnt + 3'd1;
            end else begin
                cnt_nxt = clk_cnt - CW'(1);
            end
            R_STOP: if (clk_cnt == '0) begin
                byte_ok  = rx_sync;
                ferr_set = !rx_sync;
                r_nxt    = R_IDLE;
            end else begin
                cnt_nxt = clk_cnt - CW'(1);
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_num   = 3'd0;
        if (byte_ok) begin
            if (shreg >= 8'h30 && shreg <= 8'h36) begin
                cmd_valid = 1'b1;
                cmd_num   = shreg[2:0];
            end else if (shreg == 8'h52 || shreg == 8'h72) begin
                cmd_valid = 1'b1;
                cmd_num   = 3'd7;
            end
        end
    end

    always_comb begin
        s_nxt         = s_state;
        sc_nxt        = s_cnt;
        num_nxt       = number;
        ctl_nxt       = control;
        pend_full_nxt = pend_full;
        pend_nxt      = pend_num;
        ovr_set       = 1'b0;
        slot_free     = 1'b0;
        case (s_state)
            S_IDLE: if (pend_full) begin
                num_nxt   = pend_num;
                sc_nxt    = SETUP_LOAD;
                s_nxt     = S_SETUP;
                slot_free = 1'b1;
            end else if (cmd_valid) begin
                num_nxt = cmd_num;
                sc_nxt  = SETUP_LOAD;
                s_nxt   = S_SETUP;
            end
            S_SETUP: if (s_cnt == '0) begin
                ctl_nxt = 1'b1;
                sc_nxt  = PULSE_LOAD;
                s_nxt   = S_PULSE;
            end else begin
                sc_nxt = s_cnt - SW'(1);
            end
            S_PULSE: if (s_cnt == '0) begin
                ctl_nxt = 1'b0;
                sc_nxt  = SETUP_LOAD;
                s_nxt   = S_HOLD;
            end else begin
                sc_nxt = s_cnt - SW'(1);
            end
            S_HOLD: if (s_cnt == '0) begin
                if (pend_full) begin
                    num_nxt   = pend_num;
                    sc_nxt    = SETUP_LOAD;
                    s_nxt     = S_SETUP;
                    slot_free = 1'b1;
                end else begin
                    s_nxt = S_IDLE;
                end
            end else begin
                sc_nxt = s_cnt - SW'(1);
            end
            default: s_nxt = S_IDLE;
        endcase
        if (slot_free) pend_full_nxt = 1'b0;
        // a slot being emptied this clock can take the new command without overrun
        if (cmd_valid && !(s_state == S_IDLE && !pend_full)) begin
            if (!pend_full || slot_free) begin
                pend_full_nxt = 1'b1;
                pend_nxt      = cmd_num;
            end else begin
                ovr_set = 1'b1;
            end
        end
    end

    assign busy = (s_state != S_IDLE) || pend_full;

endmodule

// File: tb/tb_serial_cmd_receiver.sv
// Directed bench for serial_cmd_receiver: a default-parameter instance (a) and a
// long-pulse, fast-baud instance (b) used to exercise the pending slot and overrun.
module tb_serial_cmd_receiver;
    localparam int CPB_A = 434;
    localparam int CPB_B = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b;
    logic [2:0] number_a, number_b;
    logic       control_a, control_b, busy_a, busy_b;
    logic       frame_err_a, frame_err_b, overrun_a, overrun_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_cmd_receiver dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .number(number_a), .control(control_a),
        .busy(busy_a), .frame_err(frame_err_a), .overrun(overrun_a)
    );

    serial_cmd_receiver #(.CLK_HZ(50000000), .BAUD(1000000), .SETUP_CYCLES(4), .PULSE_CYCLES(20000)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .number(number_b), .control(control_b),
        .busy(busy_b), .frame_err(frame_err_b), .overrun(overrun_b)
    );

    // per-instance event recorder, sampled on the falling edge
    logic [2:0] num_w[2];
    logic       ctl_w[2], bsy_w[2], ferr_w[2], ovr_w[2];
    assign num_w[0] = number_a;    assign num_w[1] = number_b;
    assign ctl_w[0] = control_a;   assign ctl_w[1] = control_b;
    assign bsy_w[0] = busy_a;      assign bsy_w[1] = busy_b;
    assign ferr_w[0] = frame_err_a; assign ferr_w[1] = frame_err_b;
    assign ovr_w[0] = overrun_a;   assign ovr_w[1] = overrun_b;

    int cyc = 0;
    logic [2:0] num_p[2] = '{3'd0, 3'd0};
    logic       ctl_p[2] = '{1'b0, 1'b0};
    logic       bsy_p[2] = '{1'b0, 1'b0};
    int chg_cyc[2], rise_cyc[2], fall_cyc[2];
    int setup_len[2], width[2], hold_len[2];
    int rises[2], ferr_cnt[2], ovr_cnt[2], num5[2];
    logic [2:0] rise_num[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            chg_cyc[i] = 0; rise_cyc[i] = 0; fall_cyc[i] = 0;
            setup_len[i] = 0; width[i] = 0; hold_len[i] = 0;
            rises[i] = 0; ferr_cnt[i] = 0; ovr_cnt[i] = 0; num5[i] = 0;
            rise_num[i] = 3'd0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (num_w[i] !== num_p[i]) chg_cyc[i] = cyc;
            if (ctl_w[i] && !ctl_p[i]) begin
                rises[i]++;
                rise_cyc[i]  = cyc;
                setup_len[i] = cyc - chg_cyc[i];
                rise_num[i]  = num_w[i];
            end
            if (!ctl_w[i] && ctl_p[i]) begin
                fall_cyc[i] = cyc;
                width[i]    = cyc - rise_cyc[i];
            end
            if (!bsy_w[i] && bsy_p[i]) hold_len[i] = cyc - fall_cyc[i];
            if (ferr_w[i] === 1'b1) ferr_cnt[i]++;
            if (ovr_w[i] === 1'b1) ovr_cnt[i]++;
            if (num_w[i] == 3'd5) num5[i]++;
            num_p[i] = num_w[i];
            ctl_p[i] = ctl_w[i];
            bsy_p[i] = bsy_w[i];
        end
    end

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_byte(input int inst, input logic [7:0] b, input logic stop_lvl, input int stop_clks);
        int cpb;
        cpb = (inst == 0) ? CPB_A : CPB_B;
        set_rx(inst, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(inst, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_rx(inst, stop_lvl);
        repeat (stop_clks) @(negedge clk);
        set_rx(inst, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (number_a !== 3'd0) begin n_bad++; $display("FAIL reset_number: got %0d expected 0", number_a); end
        n_cmp++; if (control_a !== 1'b0) begin n_bad++; $display("FAIL reset_control: got %b expected 0", control_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_cmp++; if (frame_err_a !== 1'b0 || overrun_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulses: got ferr=%b ovr=%b expected 0 0", frame_err_a, overrun_a);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single();
        int r0;
        r0 = rises[0];
        send_byte(0, 8'h33, 1'b1, CPB_A);
        repeat (10) @(negedge clk);
        n_cmp++; if (rises[0] - r0 !== 1) begin n_bad++; $display("FAIL single_strobes: got %0d expected 1", rises[0] - r0); end
        n_cmp++; if (rise_num[0] !== 3'd3) begin n_bad++; $display("FAIL single_number: got %0d expected 3", rise_num[0]); end
        n_cmp++; if (setup_len[0] !== 4) begin n_bad++; $display("FAIL single_setup: got %0d expected 4", setup_len[0]); end
        n_cmp++; if (width[0] !== 8) begin n_bad++; $display("FAIL single_width: got %0d expected 8", width[0]); end
        n_cmp++; if (hold_len[0] !== 4) begin n_bad++; $display("FAIL single_hold: got %0d expected 4", hold_len[0]); end
        n_cmp++; if (number_a !== 3'd3 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL single_idle: got number=%0d busy=%b expected 3 0", number_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int r0, o0;
        r0 = rises[0];
        o0 = ovr_cnt[0];
        send_byte(0, 8'h72, 1'b1, CPB_A);
        n_cmp++; if (rise_num[0] !== 3'd7) begin n_bad++; $display("FAIL b2b_first_number: got %0d expected 7", rise_num[0]); end
        send_byte(0, 8'h52, 1'b1, CPB_A);
        repeat (10) @(negedge clk);
        n_cmp++; if (rises[0] - r0 !== 2) begin n_bad++; $display("FAIL b2b_strobes: got %0d expected 2", rises[0] - r0); end
        n_cmp++; if (rise_num[0] !== 3'd7 || width[0] !== 8) begin
            n_bad++; $display("FAIL b2b_second: got number=%0d width=%0d expected 7 8", rise_num[0], width[0]);
        end
        n_cmp++; if (ovr_cnt[0] !== o0) begin n_bad++; $display("FAIL b2b_overrun: got %0d expected %0d", ovr_cnt[0], o0); end
    endtask

    task automatic test_overrun();
        int r0, o0, k;
        r0 = rises[1];
        o0 = ovr_cnt[1];
        send_byte(1, 8'h31, 1'b1, CPB_B);
        send_byte(1, 8'h32, 1'b1, CPB_B);
        send_byte(1, 8'h35, 1'b1, CPB_B);
        repeat (10) @(negedge clk);
        n_cmp++; if (ovr_cnt[1] - o0 !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt[1] - o0); end
        n_cmp++; if (rise_num[1] !== 3'd1 || control_b !== 1'b1) begin
            n_bad++; $display("FAIL ovr_first: got number=%0d control=%b expected 1 1", rise_num[1], control_b);
        end
        k = 0;
        while (rises[1] < r0 + 2 && k < 25000) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++; if (rises[1] < r0 + 2) begin n_bad++; $display("FAIL ovr_timeout: got %0d strobes expected 2", rises[1] - r0); end
        n_cmp++; if (rise_num[1] !== 3'd2 || setup_len[1] !== 4) begin
            n_bad++; $display("FAIL ovr_second: got number=%0d setup=%0d expected 2 4", rise_num[1], setup_len[1]);
        end
        n_cmp++; if (width[1] !== 20000) begin n_bad++; $display("FAIL ovr_width: got %0d expected 20000", width[1]); end
        n_cmp++; if (chg_cyc[1] - fall_cyc[1] !== 4) begin
            n_bad++; $display("FAIL ovr_chain: got %0d expected 4", chg_cyc[1] - fall_cyc[1]);
        end
        n_cmp++; if (num5[1] !== 0) begin n_bad++; $display("FAIL ovr_no5: got %0d expected 0", num5[1]); end
    endtask

    task automatic test_ignored();
        int r0, f0;
        r0 = rises[0];
        f0 = ferr_cnt[0];
        send_byte(0, 8'h41, 1'b1, CPB_A);
        send_byte(0, 8'h37, 1'b1, CPB_A);
        repeat (10) @(negedge clk);
        n_cmp++; if (rises[0] !== r0) begin n_bad++; $display("FAIL ign_strobes: got %0d expected 0", rises[0] - r0); end
        n_cmp++; if (number_a !== 3'd7) begin n_bad++; $display("FAIL ign_number: got %0d expected 7", number_a); end
        n_cmp++; if (ferr_cnt[0] !== f0) begin n_bad++; $display("FAIL ign_ferr: got %0d expected 0", ferr_cnt[0] - f0); end
    endtask

    task automatic test_frame_err();
        int r0, f0;
        r0 = rises[0];
        f0 = ferr_cnt[0];
        send_byte(0, 8'h34, 1'b0, CPB_A);
        repeat (12 * CPB_A) @(negedge clk);
        n_cmp++; if (ferr_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt[0] - f0); end
        n_cmp++; if (rises[0] !== r0) begin n_bad++; $display("FAIL ferr_strobe: got %0d expected 0", rises[0] - r0); end
        f0 = ferr_cnt[0];
        rx_a = 1'b0;
        repeat (100) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * CPB_A) @(negedge clk);
        n_cmp++; if (ferr_cnt[0] !== f0 || rises[0] !== r0) begin
            n_bad++; $display("FAIL glitch: got ferr=%0d strobes=%0d expected 0 0", ferr_cnt[0] - f0, rises[0] - r0);
        end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_reset_abort();
        int r0, k;
        send_byte(0, 8'h33, 1'b1, 0);
        k = 0;
        while (control_a !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (control_a !== 1'b1) begin n_bad++; $display("FAIL abort_timeout: got control=%b expected 1", control_a); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (control_a !== 1'b0 || number_a !== 3'd0) begin
            n_bad++; $display("FAIL abort_async: got control=%b number=%0d expected 0 0", control_a, number_a);
        end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        r0 = rises[0];
        send_byte(0, 8'h36, 1'b1, CPB_A);
        repeat (10) @(negedge clk);
        n_cmp++; if (rises[0] - r0 !== 1) begin n_bad++; $display("FAIL abort_next_strobes: got %0d expected 1", rises[0] - r0); end
        n_cmp++; if (rise_num[0] !== 3'd6 || setup_len[0] !== 4 || width[0] !== 8) begin
            n_bad++; $display("FAIL abort_next: got number=%0d setup=%0d width=%0d expected 6 4 8",
                              rise_num[0], setup_len[0], width[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_ignored();
        test_frame_err();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
